// File: rtl/count_bcd_display.sv
// Binary 0..99 count -> two BCD digits (sequential double-dabble) -> muxed 7-segment display.
// Latency: digits commit BITS+1 clk edges after a new count is captured; seg/an follow one edge later.
// Backpressure: none; count_in changes during a conversion are ignored and re-sampled when idle.
module count_bcd_display #(
   parameter int BITS           = 7,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BLANK_LEADING  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] count_in,
   output logic [6:0]      seg,
   output logic [1:0]      an,
   output logic            busy,
   output logic            ovf
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(BITS + 1);
   localparam logic [6:0] SEG_ZERO = 7'h3F;
   localparam logic [6:0] SEG_RST  = (SEG_ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
   localparam logic [1:0] AN_RST   = (SEG_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [BITS-1:0] last_val_q, last_val_d;
   logic [BITS-1:0] sh_q, sh_d;
   logic [11:0]     bcd_q, bcd_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic [3:0]      tens_q, tens_d, ones_q, ones_d;
   logic            ovf_q, ovf_d, busy_q, busy_d;
   logic [CW-1:0]   ref_q, ref_d;
   logic            sel_q, sel_d;          // 0: ones, 1: tens
   logic [6:0]      seg_q, seg_d;
   logic [1:0]      an_q, an_d;
   logic [11:0]     adj;
   logic [3:0]      digit;
   logic [6:0]      seg_raw;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Conversion FSM: capture on change, BITS add-3/shift steps, then commit all digits at once.
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      sh_d       = sh_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      adj        = bcd_q;
      case (state_q)
         IDLE: begin
            if (count_in != last_val_q) begin
               last_val_d = count_in;
               sh_d       = count_in;
               bcd_d      = '0;
               iter_d     = '0;
               busy_d     = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            for (int n = 0; n < 3; n++) begin
               if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
            end
            bcd_d  = {adj[10:0], sh_q[BITS-1]};
            sh_d   = sh_q << 1;
            iter_d = iter_q + 1'b1;
            if (iter_q == IW'(BITS - 1)) state_d = DONE;
         end
         DONE: begin
            tens_d  = bcd_q[7:4];
            ones_d  = bcd_q[3:0];
            ovf_d   = (bcd_q[11:8] != 4'd0) || (32'(last_val_q) > 32'd99);
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Display path: refresh divider toggles the digit select; seg/an registered from committed digits.
   always_comb begin
      ref_d = ref_q + 1'b1;
      sel_d = sel_q;
      if (ref_q == CW'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         sel_d = ~sel_q;
      end
      digit = sel_q ? tens_q : ones_q;
      if (ovf_q)
         seg_raw = 7'h40;
      else if (sel_q && (BLANK_LEADING != 0) && (tens_q == 4'd0))
         seg_raw = 7'h00;
      else
         seg_raw = seg7(digit);
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      an_d  = sel_q ? 2'b10 : 2'b01;
      if (SEG_ACTIVE_LOW != 0) an_d = ~an_d;
   end

   // State registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_val_q <= '0;
         sh_q       <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         ref_q      <= '0;
         sel_q      <= 1'b0;
         seg_q      <= SEG_RST;
         an_q       <= AN_RST;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         sh_q       <= sh_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         ref_q      <= ref_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;
   assign ovf  = ovf_q;

endmodule
